// File: rtl/dsc_cache_pkg.sv
// Shared constants and types for the CoreDMA descriptor cache controller.
package dsc_cache_pkg;

    localparam int unsigned DSC_W          = 88;
    localparam int unsigned DSC_DEPTH      = 4;
    localparam int unsigned DSC_AW         = 2;
    localparam int unsigned DSC_SKID_DEPTH = 3;
    localparam int unsigned DSC_SKID_CW    = 2;

    typedef logic [DSC_W-1:0]       dsc_t;
    typedef logic [DSC_AW-1:0]      dsc_ptr_t;
    typedef logic [DSC_AW:0]        dsc_cnt_t;
    typedef logic [DSC_SKID_CW-1:0] skid_cnt_t;
    typedef logic [DSC_SKID_CW:0]   skid_sum_t;

endpackage

// File: rtl/dsc_cache_if.sv
// Descriptor handshake and cache SRAM port bundle; master is the controller side.
interface dsc_cache_if;
    import dsc_cache_pkg::*;

    logic     DSC_IN_VALID;
    logic     DSC_IN_READY;
    dsc_t     DSC_IN_DATA;
    logic     DSC_OUT_VALID;
    logic     DSC_OUT_READY;
    dsc_t     DSC_OUT_DATA;
    logic     W_EN;
    dsc_ptr_t W_ADDR;
    dsc_t     W_DATA;
    dsc_ptr_t R_ADDR;
    logic     R_ADDR_EN;
    logic     R_DATA_EN;
    logic     R_ADDR_SRST_N;
    logic     R_DATA_SRST_N;
    logic     BLK_EN;
    dsc_t     R_DATA;
    dsc_cnt_t CACHE_CNT;

    modport master (
        input  DSC_IN_VALID, DSC_IN_DATA, DSC_OUT_READY, R_DATA,
        output DSC_IN_READY, DSC_OUT_VALID, DSC_OUT_DATA, W_EN, W_ADDR, W_DATA,
               R_ADDR, R_ADDR_EN, R_DATA_EN, R_ADDR_SRST_N, R_DATA_SRST_N,
               BLK_EN, CACHE_CNT
    );

    modport slave (
        output DSC_IN_VALID, DSC_IN_DATA, DSC_OUT_READY, R_DATA,
        input  DSC_IN_READY, DSC_OUT_VALID, DSC_OUT_DATA, W_EN, W_ADDR, W_DATA,
               R_ADDR, R_ADDR_EN, R_DATA_EN, R_ADDR_SRST_N, R_DATA_SRST_N,
               BLK_EN, CACHE_CNT
    );

endinterface

// File: rtl/dsc_out_skid.sv
// Small register FIFO that absorbs SRAM read returns in front of the channel engine.
module dsc_out_skid
    import dsc_cache_pkg::*;
(
    input  logic      clk,
    input  logic      srst,
    input  logic      clr,
    input  logic      push,
    input  dsc_t      push_data,
    input  logic      pop,
    output dsc_t      head,
    output skid_cnt_t count,
    output logic      empty
);

    dsc_t      mem_q [DSC_SKID_DEPTH];
    dsc_t      mem_d [DSC_SKID_DEPTH];
    skid_cnt_t rd_q, rd_d;
    skid_cnt_t wr_q, wr_d;
    skid_cnt_t cnt_q, cnt_d;
    logic      do_pop;

    function automatic skid_cnt_t nxt(input skid_cnt_t p);
        return (p == skid_cnt_t'(DSC_SKID_DEPTH - 1)) ? '0 : p + skid_cnt_t'(1);
    endfunction

    // Next-state for storage, pointers and occupancy; clr empties the FIFO.
    always_comb begin
        mem_d  = mem_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        do_pop = pop & (cnt_q != '0);
        if (push) begin
            mem_d[wr_q] = push_data;
            wr_d        = nxt(wr_q);
        end
        if (do_pop) begin
            rd_d = nxt(rd_q);
        end
        cnt_d = cnt_q + skid_cnt_t'(push) - skid_cnt_t'(do_pop);
        if (clr) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage needs no reset; occupancy qualifies it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign head  = empty ? '0 : mem_q[rd_q];

endmodule

// File: rtl/dsc_cache_ctrl.sv
// Descriptor cache controller: FIFO sequencing over a 4-entry SRAM with a
// 2-cycle registered read path and an output skid buffer.
// Optional macro DSC_CACHE_FLUSH_EN adds a FLUSH input that clears all state.
module dsc_cache_ctrl
    import dsc_cache_pkg::*;
(
    input  logic CLK,
    input  logic SRST,
`ifdef DSC_CACHE_FLUSH_EN
    input  logic FLUSH,
`endif
    dsc_cache_if.master bus
);

    dsc_ptr_t  wptr_q, wptr_d;
    dsc_ptr_t  rptr_q, rptr_d;
    dsc_cnt_t  cnt_q, cnt_d;
    logic      v1_q, v1_d;
    logic      v2_q, v2_d;
    logic      flush;
    logic      in_ready;
    logic      wr;
    logic      issue;
    skid_sum_t pend;
    skid_cnt_t skid_cnt;
    logic      skid_empty;
    dsc_t      skid_head;

`ifdef DSC_CACHE_FLUSH_EN
    assign flush = FLUSH;
`else
    assign flush = 1'b0;
`endif

    // Write acceptance, read issue and the next pointer/count/tag values.
    always_comb begin
        in_ready = (cnt_q < dsc_cnt_t'(DSC_DEPTH)) & ~flush;
        wr       = bus.DSC_IN_VALID & in_ready;
        pend     = skid_sum_t'(skid_cnt) + skid_sum_t'(v1_q) + skid_sum_t'(v2_q);
        issue    = (cnt_q != '0) & (pend < skid_sum_t'(DSC_SKID_DEPTH)) & ~flush;
        wptr_d   = wr ? wptr_q + dsc_ptr_t'(1) : wptr_q;
        rptr_d   = issue ? rptr_q + dsc_ptr_t'(1) : rptr_q;
        cnt_d    = cnt_q + dsc_cnt_t'(wr) - dsc_cnt_t'(issue);
        v1_d     = issue;
        v2_d     = v1_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            v1_d   = 1'b0;
            v2_d   = 1'b0;
        end
    end

    // Pointer, count and in-flight tag registers.
    always_ff @(posedge CLK) begin
        if (SRST) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            v1_q   <= v1_d;
            v2_q   <= v2_d;
        end
    end

    dsc_out_skid u_skid (
        .clk       (CLK),
        .srst      (SRST),
        .clr       (flush),
        .push      (v2_q),
        .push_data (bus.R_DATA),
        .pop       (bus.DSC_OUT_VALID & bus.DSC_OUT_READY),
        .head      (skid_head),
        .count     (skid_cnt),
        .empty     (skid_empty)
    );

    assign bus.DSC_IN_READY  = in_ready;
    assign bus.W_EN          = wr;
    assign bus.W_ADDR        = wptr_q;
    assign bus.W_DATA        = bus.DSC_IN_DATA;
    assign bus.R_ADDR        = rptr_q;
    assign bus.R_ADDR_EN     = issue;
    assign bus.R_DATA_EN     = v1_q;
    assign bus.R_ADDR_SRST_N = ~SRST;
    assign bus.R_DATA_SRST_N = ~SRST;
    assign bus.BLK_EN        = 1'b1;
    assign bus.DSC_OUT_VALID = ~skid_empty;
    assign bus.DSC_OUT_DATA  = skid_head;
    assign bus.CACHE_CNT     = cnt_q;

endmodule

// File: tb/tb_dsc_cache_ctrl.sv
// Bench for dsc_cache_ctrl: SRAM model, queue-based reference, directed and random traffic.
module tb_dsc_cache_ctrl;
    import dsc_cache_pkg::*;

    typedef logic [127:0] w_t;
    typedef struct {
        dsc_t d;
        int   c;
    } fl_t;

    logic CLK = 1'b0;
    logic SRST = 1'b1;
    logic flush_i = 1'b0;

    dsc_cache_if bus ();

    dsc_cache_ctrl dut (
        .CLK   (CLK),
        .SRST  (SRST),
`ifdef DSC_CACHE_FLUSH_EN
        .FLUSH (flush_i),
`endif
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input w_t act, input w_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // SRAM with registered address and data stages.
    dsc_t     mem [DSC_DEPTH];
    dsc_ptr_t ra_q;
    dsc_t     rd_q;
    assign bus.R_DATA = rd_q;

    always @(posedge CLK) begin
        if (bus.W_EN === 1'b1) mem[bus.W_ADDR] <= bus.W_DATA;
        if (bus.R_ADDR_SRST_N !== 1'b1) ra_q <= '0;
        else if (bus.R_ADDR_EN === 1'b1) ra_q <= bus.R_ADDR;
        if (bus.R_DATA_SRST_N !== 1'b1) rd_q <= '0;
        else if (bus.R_DATA_EN === 1'b1) rd_q <= mem[ra_q];
    end

    // Reference model: ordered queues plus a list of reads with their issue cycle.
    dsc_t cache_m [$];
    dsc_t skid_m  [$];
    fl_t  infl_m  [$];
    dsc_t out_log [$];
    int   wr_tot = 0;
    int   rd_tot = 0;
    int   ncyc = 0;
    bit   model_on = 1'b0;

    always @(negedge CLK) begin
        bit   e_ready, e_valid, e_wr, e_issue, e_v1;
        fl_t  tf;
        dsc_t td;
        ncyc++;
        e_ready = (cache_m.size() < 4) && !flush_i;
        e_valid = skid_m.size() > 0;
        e_wr    = (bus.DSC_IN_VALID === 1'b1) && e_ready;
        e_issue = !flush_i && (cache_m.size() > 0) && (skid_m.size() + infl_m.size() < 3);
        e_v1    = 1'b0;
        foreach (infl_m[i]) if (infl_m[i].c == ncyc - 1) e_v1 = 1'b1;
        if (model_on) begin
            chk("in_ready", w_t'(bus.DSC_IN_READY), w_t'(e_ready));
            chk("out_valid", w_t'(bus.DSC_OUT_VALID), w_t'(e_valid));
            if (e_valid) chk("out_data", w_t'(bus.DSC_OUT_DATA), w_t'(skid_m[0]));
            chk("cache_cnt", w_t'(bus.CACHE_CNT), w_t'(cache_m.size()));
            chk("w_en", w_t'(bus.W_EN), w_t'(e_wr));
            if (e_wr) begin
                chk("w_addr", w_t'(bus.W_ADDR), w_t'(wr_tot % 4));
                chk("w_data", w_t'(bus.W_DATA), w_t'(bus.DSC_IN_DATA));
            end
            chk("r_addr_en", w_t'(bus.R_ADDR_EN), w_t'(e_issue));
            if (e_issue) chk("r_addr", w_t'(bus.R_ADDR), w_t'(rd_tot % 4));
            chk("r_data_en", w_t'(bus.R_DATA_EN), w_t'(e_v1));
            chk("r_addr_srst_n", w_t'(bus.R_ADDR_SRST_N), w_t'(!SRST));
            chk("r_data_srst_n", w_t'(bus.R_DATA_SRST_N), w_t'(!SRST));
            chk("blk_en", w_t'(bus.BLK_EN), w_t'(1));
        end
        if (bus.DSC_OUT_VALID === 1'b1 && bus.DSC_OUT_READY === 1'b1) out_log.push_back(bus.DSC_OUT_DATA);
        if (SRST || (model_on && flush_i)) begin
            cache_m.delete();
            skid_m.delete();
            infl_m.delete();
            wr_tot = 0;
            rd_tot = 0;
            if (SRST) model_on = 1'b1;
        end else if (model_on) begin
            if (e_valid && bus.DSC_OUT_READY) void'(skid_m.pop_front());
            if (infl_m.size() > 0 && infl_m[0].c == ncyc - 2) begin
                tf = infl_m.pop_front();
                skid_m.push_back(tf.d);
            end
            if (e_issue) begin
                td = cache_m.pop_front();
                infl_m.push_back('{d: td, c: ncyc});
                rd_tot++;
            end
            if (e_wr) begin
                cache_m.push_back(bus.DSC_IN_DATA);
                wr_tot++;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offer values until n are accepted or the cycle budget runs out.
    task automatic send(input dsc_t vals [$], input bit toggle, output int acc);
        int k;
        bit rdy;
        acc = 0;
        k = 0;
        while (acc < vals.size() && k < 400) begin
            bus.DSC_IN_VALID = 1'b1;
            bus.DSC_IN_DATA  = vals[acc];
            if (toggle) bus.DSC_OUT_READY = k[0];
            rdy = bus.DSC_IN_READY;
            tick();
            if (rdy) acc++;
            k++;
        end
        bus.DSC_IN_VALID = 1'b0;
    endtask

    task automatic wait_log(input int n, input bit toggle);
        int k;
        k = 0;
        while (out_log.size() < n && k < 200) begin
            if (toggle) bus.DSC_OUT_READY = k[0];
            tick();
            k++;
        end
    endtask

    task automatic cmp_log(input string nm, input dsc_t exp [$]);
        int bad;
        bad = 0;
        chk({nm, "_count"}, w_t'(out_log.size()), w_t'(exp.size()));
        foreach (exp[i]) if (i >= out_log.size() || out_log[i] !== exp[i]) bad++;
        chk({nm, "_order"}, w_t'(bad), w_t'(0));
    endtask

    initial begin
        dsc_t vals [$];
        int   acc, lat, bad;
        bus.DSC_IN_VALID  = 1'b0;
        bus.DSC_IN_DATA   = '0;
        bus.DSC_OUT_READY = 1'b0;
        tick();
        tick();
        SRST = 1'b0;
        chk("rst_in_ready", w_t'(bus.DSC_IN_READY), w_t'(1));
        chk("rst_out_valid", w_t'(bus.DSC_OUT_VALID), w_t'(0));
        chk("rst_out_data", w_t'(bus.DSC_OUT_DATA), w_t'(0));
        chk("rst_cnt", w_t'(bus.CACHE_CNT), w_t'(0));
        chk("rst_r_addr_en", w_t'(bus.R_ADDR_EN), w_t'(0));
        chk("rst_r_data_en", w_t'(bus.R_DATA_EN), w_t'(0));

        // Single descriptor latency.
        bus.DSC_OUT_READY = 1'b1;
        bus.DSC_IN_DATA   = 88'hA5;
        bus.DSC_IN_VALID  = 1'b1;
        tick();
        bus.DSC_IN_VALID = 1'b0;
        lat = 0;
        while (bus.DSC_OUT_VALID !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        chk("first_latency", w_t'(lat), w_t'(3));
        chk("first_data", w_t'(bus.DSC_OUT_DATA), w_t'(88'hA5));
        tick();
        tick();
        chk("first_drained_cnt", w_t'(bus.CACHE_CNT), w_t'(0));
        chk("first_drained_valid", w_t'(bus.DSC_OUT_VALID), w_t'(0));

        // Burst of 8 against a stalled consumer.
        out_log.delete();
        bus.DSC_OUT_READY = 1'b0;
        vals.delete();
        for (int i = 1; i <= 8; i++) vals.push_back(dsc_t'(i));
        send(vals, 1'b0, acc);
        chk("burst_accepted", w_t'(acc), w_t'(7));
        chk("burst_cnt_full", w_t'(bus.CACHE_CNT), w_t'(4));
        chk("burst_in_ready", w_t'(bus.DSC_IN_READY), w_t'(0));
        bus.DSC_OUT_READY = 1'b1;
        vals.delete();
        vals.push_back(dsc_t'(8));
        send(vals, 1'b0, acc);
        wait_log(8, 1'b0);
        vals.delete();
        for (int i = 1; i <= 8; i++) vals.push_back(dsc_t'(i));
        cmp_log("burst", vals);

        // Streaming with an always-ready consumer.
        out_log.delete();
        vals.delete();
        for (int i = 0; i < 32; i++) vals.push_back(dsc_t'(100 + i));
        send(vals, 1'b0, acc);
        wait_log(32, 1'b0);
        cmp_log("stream", vals);

        // Consumer ready every other cycle.
        out_log.delete();
        vals.delete();
        for (int i = 0; i < 40; i++) vals.push_back(dsc_t'({$urandom(), $urandom(), $urandom()}));
        send(vals, 1'b1, acc);
        wait_log(40, 1'b1);
        cmp_log("toggle", vals);

        // Reset with two reads in flight.
        bus.DSC_OUT_READY = 1'b1;
        repeat (8) tick();
        bus.DSC_OUT_READY = 1'b0;
        vals.delete();
        for (int i = 0; i < 3; i++) vals.push_back(dsc_t'(8'h11 + i));
        send(vals, 1'b0, acc);
        SRST = 1'b1;
        tick();
        SRST = 1'b0;
        chk("srst_out_valid", w_t'(bus.DSC_OUT_VALID), w_t'(0));
        chk("srst_cnt", w_t'(bus.CACHE_CNT), w_t'(0));
        chk("srst_in_ready", w_t'(bus.DSC_IN_READY), w_t'(1));
        out_log.delete();
        bus.DSC_OUT_READY = 1'b1;
        vals.delete();
        vals.push_back(dsc_t'(88'h5A));
        send(vals, 1'b0, acc);
        repeat (10) tick();
        cmp_log("srst_after", vals);

`ifdef DSC_CACHE_FLUSH_EN
        // Flush with 3 cached, 1 in flight, 2 in the skid.
        bus.DSC_OUT_READY = 1'b0;
        vals.delete();
        for (int i = 0; i < 7; i++) vals.push_back(dsc_t'(8'h31 + i));
        send(vals, 1'b0, acc);
        repeat (4) tick();
        bus.DSC_OUT_READY = 1'b1;
        tick();
        bus.DSC_OUT_READY = 1'b0;
        tick();
        chk("pre_flush_cnt", w_t'(bus.CACHE_CNT), w_t'(3));
        chk("pre_flush_r_data_en", w_t'(bus.R_DATA_EN), w_t'(1));
        flush_i = 1'b1;
        bus.DSC_IN_VALID = 1'b1;
        bus.DSC_IN_DATA  = 88'hEE;
        chk("flush_in_ready", w_t'(bus.DSC_IN_READY), w_t'(0));
        chk("flush_w_en", w_t'(bus.W_EN), w_t'(0));
        tick();
        flush_i = 1'b0;
        bus.DSC_IN_VALID = 1'b0;
        chk("flush_out_valid", w_t'(bus.DSC_OUT_VALID), w_t'(0));
        chk("flush_cnt", w_t'(bus.CACHE_CNT), w_t'(0));
        out_log.delete();
        bus.DSC_OUT_READY = 1'b1;
        vals.delete();
        vals.push_back(dsc_t'(88'h77));
        send(vals, 1'b0, acc);
        repeat (10) tick();
        cmp_log("flush_after", vals);
`endif

        // Random traffic, checked cycle by cycle against the model.
        for (int k = 0; k < 600; k++) begin
            bus.DSC_IN_VALID  = ($urandom_range(0, 99) < 70);
            bus.DSC_IN_DATA   = dsc_t'({$urandom(), $urandom(), $urandom()});
            bus.DSC_OUT_READY = ($urandom_range(0, 99) < 60);
            SRST = ($urandom_range(0, 199) == 0);
`ifdef DSC_CACHE_FLUSH_EN
            flush_i = ($urandom_range(0, 59) == 0);
`endif
            tick();
        end
        SRST = 1'b0;
        flush_i = 1'b0;
        bus.DSC_IN_VALID  = 1'b0;
        bus.DSC_OUT_READY = 1'b1;
        repeat (12) tick();
        chk("final_cnt", w_t'(bus.CACHE_CNT), w_t'(0));
        chk("final_out_valid", w_t'(bus.DSC_OUT_VALID), w_t'(0));
        bad = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
